// File: rtl/cordic_fixed_to_float_ppl.sv
// Three-stage converter from the CORDIC's signed fixed-point word (dataa / 2^FRAC)
// to an IEEE-754 single. All stages advance together on clk_en.
module cordic_fixed_to_float_ppl #(
  parameter int WL       = 22,
  parameter int FRAC     = 20,
  parameter int EXP_BIAS = 127
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clk_en,
  input  logic                 valid_in,
  input  logic signed [WL-1:0] dataa,
  output logic [31:0]          result,
  output logic                 valid_out
);

  localparam int PW = 5;

  function automatic logic [PW-1:0] msb_index(input logic [WL-1:0] v);
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = 0; i < WL; i++) begin
      if (v[i]) idx = PW'(i);
    end
    return idx;
  endfunction

  // Bits below the leading one, left-aligned into the 23-bit fraction field.
  function automatic logic [22:0] norm_frac(input logic [WL-1:0] mag, input logic [PW-1:0] p);
    return 23'({mag, 23'b0} >> p);
  endfunction

  // Modulo-256 arithmetic is exact because the true exponent always lies in 1..254.
  function automatic logic [7:0] exp_of(input logic [PW-1:0] p);
    return 8'(EXP_BIAS) + 8'(p) - 8'(FRAC);
  endfunction

  logic [WL-1:0] w_mag;
  logic [PW-1:0] w_p;
  logic [22:0]   w_frac;
  logic [31:0]   w_result;

  logic          r_sign_p0, r_zero_p0, r_vld_p0;
  logic [WL-1:0] r_mag_p0;
  logic          r_sign_p1, r_zero_p1, r_vld_p1;
  logic [PW-1:0] r_p_p1;
  logic [22:0]   r_frac_p1;
  logic [31:0]   r_result_p2;
  logic          r_vld_p2;

  assign w_mag    = dataa[WL-1] ? $unsigned(-dataa) : $unsigned(dataa);
  assign w_p      = msb_index(r_mag_p0);
  assign w_frac   = norm_frac(r_mag_p0, w_p);
  assign w_result = r_zero_p1 ? 32'h0 : {r_sign_p1, exp_of(r_p_p1), r_frac_p1};

  // Stage p0: sign, magnitude, zero detect
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sign_p0 <= 1'b0;
      r_zero_p0 <= 1'b0;
      r_mag_p0  <= '0;
      r_vld_p0  <= 1'b0;
    end else if (clk_en) begin
      r_sign_p0 <= dataa[WL-1];
      r_zero_p0 <= (dataa == '0);
      r_mag_p0  <= w_mag;
      r_vld_p0  <= valid_in;
    end
  end

  // Stage p1: leading-one position and normalisation
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sign_p1 <= 1'b0;
      r_zero_p1 <= 1'b0;
      r_p_p1    <= '0;
      r_frac_p1 <= '0;
      r_vld_p1  <= 1'b0;
    end else if (clk_en) begin
      r_sign_p1 <= r_sign_p0;
      r_zero_p1 <= r_zero_p0;
      r_p_p1    <= w_p;
      r_frac_p1 <= w_frac;
      r_vld_p1  <= r_vld_p0;
    end
  end

  // Stage p2: exponent and packed result
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_result_p2 <= 32'h0;
      r_vld_p2    <= 1'b0;
    end else if (clk_en) begin
      r_result_p2 <= w_result;
      r_vld_p2    <= r_vld_p1;
    end
  end

  assign result    = r_result_p2;
  assign valid_out = r_vld_p2;

endmodule

// File: tb/tb_cordic_fixed_to_float_ppl.sv
// Randomised and directed bench for cordic_fixed_to_float_ppl against a real-arithmetic reference.
module tb_cordic_fixed_to_float_ppl;

  localparam int WL   = 22;
  localparam int FRAC = 20;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic                 clk_en = 1'b0;
  logic                 valid_in = 1'b0;
  logic signed [WL-1:0] dataa = '0;
  logic [31:0]          result;
  logic                 valid_out;

  int n_cmp = 0;
  int n_bad = 0;

  cordic_fixed_to_float_ppl #(.WL(WL), .FRAC(FRAC), .EXP_BIAS(127)) dut (
    .clock(clock), .reset(reset), .clk_en(clk_en), .valid_in(valid_in),
    .dataa(dataa), .result(result), .valid_out(valid_out)
  );

  always #5 clock = ~clock;

  // Reference: exact value as a double, repacked into single-precision fields.
  function automatic logic [31:0] ref_float(input logic [WL-1:0] d);
    logic signed [WL-1:0] s;
    int v;
    real r;
    logic [63:0] b;
    int e;
    s = d;
    v = s;
    if (v == 0) return 32'h0;
    r = real'(v) / real'(64'(1) << FRAC);
    b = $realtobits(r);
    e = int'(b[62:52]) - 1023 + 127;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Latency model: three enabled edges from capture to output.
  logic        m_vld [3];
  logic [31:0] m_res [3];
  logic        m_hold = 1'b0;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        m_vld[i] <= 1'b0;
        m_res[i] <= 32'h0;
      end
      m_hold <= 1'b0;
    end else begin
      m_hold <= !clk_en;
      if (clk_en) begin
        m_vld[0] <= valid_in;
        m_res[0] <= ref_float(dataa);
        m_vld[1] <= m_vld[0];
        m_res[1] <= m_res[0];
        m_vld[2] <= m_vld[1];
        m_res[2] <= m_res[1];
      end
    end
  end

  logic [31:0] prev_res = 32'h0;
  logic        prev_vo  = 1'b0;
  always @(negedge clock) begin
    if (!reset) begin
      chk("reset_valid_out", {31'b0, valid_out}, 32'h0);
      chk("reset_result", result, 32'h0);
    end else begin
      chk("valid_out", {31'b0, valid_out}, {31'b0, m_vld[2]});
      if (m_vld[2]) chk("result", result, m_res[2]);
      if (m_hold) begin
        chk("stall_valid_hold", {31'b0, valid_out}, {31'b0, prev_vo});
        chk("stall_result_hold", result, prev_res);
      end
    end
    prev_res = result;
    prev_vo  = valid_out;
  end

  task automatic drive(input logic en, input logic vin, input logic [WL-1:0] d);
    @(negedge clock);
    clk_en   = en;
    valid_in = vin;
    dataa    = d;
  endtask

  task automatic directed(input string name, input logic [WL-1:0] d, input logic [31:0] exp);
    drive(1'b1, 1'b1, d);
    drive(1'b1, 1'b0, '0);
    @(negedge clock);
    @(negedge clock);
    chk({name, "_valid"}, {31'b0, valid_out}, 32'h1);
    chk(name, result, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WL-1:0] d;
    // Model pinned to hand-computed encodings
    chk("model_one",     ref_float(22'h100000), 32'h3F800000);
    chk("model_half",    ref_float(22'h080000), 32'h3F000000);
    chk("model_m_one",   ref_float(22'h300000), 32'hBF800000);
    chk("model_lsb",     ref_float(22'h000001), 32'h35800000);
    chk("model_maxpos",  ref_float(22'h1FFFFF), 32'h3FFFFFF8);
    chk("model_mostneg", ref_float(22'h200000), 32'hC0000000);

    // Held in reset with random data
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, WL'($urandom));
    #2 reset = 1'b1;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, WL'($urandom));

    directed("d_one",     22'h100000, 32'h3F800000);
    directed("d_half",    22'h080000, 32'h3F000000);
    directed("d_m_one",   22'h300000, 32'hBF800000);
    directed("d_zero",    22'h000000, 32'h00000000);
    directed("d_lsb",     22'h000001, 32'h35800000);
    directed("d_maxpos",  22'h1FFFFF, 32'h3FFFFFF8);
    directed("d_mostneg", 22'h200000, 32'hC0000000);

    // Stall: samples only advance on enabled edges
    drive(1'b1, 1'b1, 22'h100000);
    drive(1'b0, 1'b1, 22'h080000);
    drive(1'b0, 1'b1, 22'h080000);
    drive(1'b1, 1'b1, 22'h080000);
    drive(1'b0, 1'b1, 22'h300000);
    drive(1'b1, 1'b1, 22'h300000);
    drive(1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, '0);
    drive(1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, '0);
    drive(1'b1, 1'b0, '0);
    drive(1'b1, 1'b0, '0);

    // Reset mid-flight
    drive(1'b1, 1'b1, 22'h100000);
    drive(1'b1, 1'b1, 22'h080000);
    drive(1'b1, 1'b1, 22'h300000);
    @(negedge clock);
    valid_in = 1'b0;
    chk("pre_reset_valid", {31'b0, valid_out}, 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_valid", {31'b0, valid_out}, 32'h0);
    chk("async_reset_result", result, 32'h0);
    drive(1'b1, 1'b0, '0);
    #2 reset = 1'b1;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, WL'($urandom));

    // Random regression
    for (int i = 0; i < 10000; i++) begin
      case ($urandom_range(0, 9))
        0:       d = 22'h200000;
        1:       d = 22'h1FFFFF;
        2:       d = 22'h000000;
        3:       d = WL'($urandom_range(1, 8));
        default: d = WL'($urandom);
      endcase
      drive(($urandom_range(0, 3) != 0), 1'($urandom), d);
    end
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, '0);

    @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cordic_fixed_to_float_ppl.md
Name: cordic_fixed_to_float_ppl

Overview:
- Pipelined converter directly downstream of cordic_pipeline.
- Takes the signed fixed-point cosine word produced by the CORDIC and converts it to an IEEE-754 single-precision value.
- Output drives the 32-bit custom-instruction result path.
- Three register stages; shares the CORDIC's clk_en so the whole datapath stalls together.

Parameters:
- WL, 22, input word length: two's complement, sign bit included. Legal range 4..25, so conversion is always exact.
- FRAC, 20, number of fractional bits in the input word. Legal range 0..WL-1.
- EXP_BIAS, 127, IEEE-754 single exponent bias. Fixed; not to be overridden.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- clk_en  input  1  pipeline advance enable; all stages hold when 0.
- valid_in  input  1  dataa carries a sample this cycle.
- dataa  input  WL  signed fixed-point value = dataa / 2^FRAC.
- result  output  32  IEEE-754 single (sign, 8-bit exponent, 23-bit fraction).
- valid_out  output  1  result holds a converted sample.

Behaviour:
- Reset (reset=0, async):
  - All pipeline registers clear.
  - result=32'h0, valid_out=0.
  - Release is synchronous to the next clock; the first capture happens on the first rising edge with reset=1 and clk_en=1.
- Advance: registers update only on rising edges with clk_en=1. With clk_en=0, every stage, result and valid_out hold their values.
- Latency:
  - Exactly 3 enabled edges from capture of dataa/valid_in to result/valid_out.
  - Throughput is 1 sample per enabled cycle.
  - valid travels as a 3-bit shift chain alongside the data.
  - Data registers load on every enabled edge regardless of valid_in.
  - When valid_out=0, result is don't-care for checking.
- Stage 1:
  - sign = dataa[WL-1].
  - mag = |dataa|, computed WL bits wide so that -2^(WL-1) yields magnitude 2^(WL-1) without overflow.
  - zero flag = (dataa==0).
- Stage 2:
  - p = index of the most-significant 1 in mag (priority encoder, 0..WL-1).
  - norm = mag shifted left so that bit p lands at bit 23 of a 24-bit field. Bits below the shifted LSB are 0.
- Stage 3:
  - exponent = EXP_BIAS + p - FRAC, 8 bits. For legal parameters it stays in 1..254: no overflow, no subnormals.
  - fraction = norm[22:0]. No rounding is needed because WL<=25.
  - result = {sign, exponent, fraction}.
  - If the zero flag is set, result = 32'h00000000 (positive zero; negative zero is never produced).
- Boundary cases:
  - Most-negative input converts exactly to -2^(WL-1-FRAC).
  - Maximum positive input converts exactly.
  - 1 LSB converts to 2^-FRAC.
- Back-to-back samples with interleaved clk_en=0 cycles must emerge in order, none dropped or duplicated.
- Reset asserted mid-stream flushes all in-flight samples; valid_out drops immediately (asynchronously) and stays 0 for 3 enabled edges after release unless new valid_in arrives.
- No backpressure beyond clk_en; the consumer must accept result whenever valid_out=1.

Test Plan (WL=22, FRAC=20):
1. Reset/idle: hold reset=0, drive random dataa -> result=32'h0, valid_out=0 throughout. Release reset with valid_in=0 -> valid_out stays 0.
2. Directed values, clk_en=1:
   - dataa 22'h100000 (1.0) -> 32'h3F800000 on the 3rd edge.
   - 22'h080000 (0.5) -> 32'h3F000000.
   - 22'h300000 (-1.0) -> 32'hBF800000.
   - 22'h000000 -> 32'h00000000.
3. Extremes:
   - 22'h000001 -> 32'h35800000.
   - 22'h1FFFFF -> 32'h3FFFFFF8.
   - 22'h200000 (-2.0) -> 32'hC0000000.
4. Stall: stream 1.0, 0.5, -1.0 on consecutive cycles with clk_en toggling 1,0,0,1,... -> outputs appear in order after exactly 3 enabled edges each. Result/valid_out remain frozen during clk_en=0.
5. Reset mid-flight: load 3 valid samples, assert reset between edges -> valid_out=0 and result=0 immediately, without waiting for an edge. After release, no stale sample emerges.
6. Random regression: 10k random dataa with random valid_in/clk_en -> each valid result equals the reference model's float of dataa/2^20, bit-exact.
